// File: rtl/const_pack.sv
// Shared constants for the phase-interpolator control path.
//   Npi             : bits per PI code
//   Nout            : number of PI channels on the control bus
//   pi_seq_state_t  : states of the PI control sequencer
package const_pack;

    localparam int Npi  = 9;
    localparam int Nout = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STEP   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4
    } pi_seq_state_t;

endpackage

// File: rtl/pi_step_calc.sv
// Single-channel PI slew step, purely combinational.
// Moves cur toward tgt by at most max_step codes along the shorter way
// around the circle of 2**Npi codes; an exact half-circle distance goes forward.
//   cur      : current live code
//   tgt      : target code
//   max_step : largest allowed change (0 behaves as 1)
//   nxt      : code after this step
//   done     : cur already equals tgt
module pi_step_calc
    import const_pack::*;
(
    input  logic [Npi-1:0] cur,
    input  logic [Npi-1:0] tgt,
    input  logic [Npi-1:0] max_step,
    output logic [Npi-1:0] nxt,
    output logic           done
);

    localparam logic [Npi-1:0] HALF = {1'b1, {(Npi-1){1'b0}}};

    logic [Npi-1:0] dist_fwd;
    logic [Npi-1:0] dist_bwd;
    logic [Npi-1:0] step_lim;

    always_comb begin
        // Modular subtraction gives the forward distance; its negation the backward one.
        dist_fwd = tgt - cur;
        dist_bwd = '0 - dist_fwd;
        step_lim = (max_step == '0) ? {{(Npi-1){1'b0}}, 1'b1} : max_step;
        done     = (dist_fwd == '0);
        nxt      = cur;
        if (dist_fwd == '0) begin
            nxt = cur;
        end else if (dist_fwd <= HALF) begin
            nxt = cur + ((dist_fwd < step_lim) ? dist_fwd : step_lim);
        end else begin
            nxt = cur - ((dist_bwd < step_lim) ? dist_bwd : step_lim);
        end
    end

endmodule

// File: rtl/pi_ctl_sequencer.sv
// Drives the 4-channel PI control bus toward an accepted target in bounded
// steps, framing each update as setup -> strobe -> hold.
//   clk_adc   : sole clock
//   rstb      : asynchronous active-low reset
//   en        : sequencer enable
//   max_step  : max code change per step per channel (0 acts as 1)
//   tgt_pi    : target codes, channel k at [k*Npi +: Npi]
//   tgt_valid : target offered
//   tgt_ready : target accepted when tgt_valid && tgt_ready
//   ctl_pi    : live PI codes
//   ctl_valid : PI code strobe
//   busy      : slew in progress
//   n_updates : strobes issued, saturating
module pi_ctl_sequencer
    import const_pack::*;
#(
    parameter int SETUP_CYC = 2,
    parameter int VALID_CYC = 1,
    parameter int HOLD_CYC  = 2
) (
    input  logic                 clk_adc,
    input  logic                 rstb,
    input  logic                 en,
    input  logic [Npi-1:0]       max_step,
    input  logic [Nout*Npi-1:0]  tgt_pi,
    input  logic                 tgt_valid,
    output logic                 tgt_ready,
    output logic [Nout*Npi-1:0]  ctl_pi,
    output logic                 ctl_valid,
    output logic                 busy,
    output logic [15:0]          n_updates
);

    localparam int MAX_CYC = (SETUP_CYC > VALID_CYC)
                           ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                           : ((VALID_CYC > HOLD_CYC) ? VALID_CYC : HOLD_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t SETUP_LAST = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t VALID_LAST = cnt_t'(VALID_CYC - 1);
    localparam cnt_t HOLD_LAST  = cnt_t'(HOLD_CYC - 1);

    pi_seq_state_t        state, state_d;
    cnt_t                 cnt, cnt_d;
    logic [Nout*Npi-1:0]  tgt_reg, tgt_reg_d;
    logic [Nout*Npi-1:0]  nxt_pi;
    logic [Nout*Npi-1:0]  ctl_pi_d;
    logic [Nout-1:0]      ch_done;
    logic                 all_done;
    logic                 ctl_valid_d, tgt_ready_d, busy_d;
    logic [15:0]          n_updates_d;
    logic                 accept;
    logic                 frame_end;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    for (genvar k = 0; k < Nout; k++) begin : g_ch
        pi_step_calc u_calc (
            .cur      (ctl_pi[k*Npi +: Npi]),
            .tgt      (tgt_reg[k*Npi +: Npi]),
            .max_step (max_step),
            .nxt      (nxt_pi[k*Npi +: Npi]),
            .done     (ch_done[k])
        );
    end

    assign all_done = &ch_done;
    assign accept   = (state == IDLE) && tgt_valid && tgt_ready;

    // One counter times every frame phase; it restarts on each phase entry.
    always_comb begin
        frame_end = 1'b0;
        case (state)
            SETUP:   frame_end = (cnt == SETUP_LAST);
            STROBE:  frame_end = (cnt == VALID_LAST);
            HOLD:    frame_end = (cnt == HOLD_LAST);
            default: frame_end = 1'b0;
        endcase
    end

    // ---- state register ----
    always_ff @(posedge clk_adc or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            cnt       <= '0;
            tgt_reg   <= '0;
            ctl_pi    <= '0;
            ctl_valid <= 1'b0;
            tgt_ready <= 1'b0;
            busy      <= 1'b0;
            n_updates <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            tgt_reg   <= tgt_reg_d;
            ctl_pi    <= ctl_pi_d;
            ctl_valid <= ctl_valid_d;
            tgt_ready <= tgt_ready_d;
            busy      <= busy_d;
            n_updates <= n_updates_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = STEP;
            STEP:    state_d = all_done ? IDLE : SETUP;
            SETUP:   if (frame_end) state_d = STROBE;
            STROBE:  if (frame_end) state_d = HOLD;
            HOLD:    if (frame_end) state_d = en ? STEP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---- registered-output next values ----
    always_comb begin
        cnt_d       = '0;
        tgt_reg_d   = tgt_reg;
        ctl_pi_d    = ctl_pi;
        busy_d      = busy;
        n_updates_d = n_updates;

        if ((state == SETUP || state == STROBE || state == HOLD) && !frame_end) begin
            cnt_d = cnt + cnt_t'(1);
        end

        if (accept) begin
            tgt_reg_d = tgt_pi;
            busy_d    = 1'b1;
        end

        // Codes move only when leaving STEP, so they are frozen for the whole frame.
        if (state == STEP) begin
            if (all_done) begin
                busy_d = 1'b0;
            end else begin
                ctl_pi_d = nxt_pi;
            end
        end

        if (state == SETUP && frame_end) begin
            n_updates_d = sat_inc(n_updates);
        end

        // Disabled mid-slew: the frame just finished, abandon the target.
        if (state == HOLD && frame_end && !en) begin
            busy_d    = 1'b0;
            tgt_reg_d = '0;
        end

        ctl_valid_d = (state_d == STROBE);
        tgt_ready_d = (state_d == IDLE) && en;
    end

endmodule

// File: tb/tb_pi_ctl_sequencer.sv
module tb_pi_ctl_sequencer;
    import const_pack::*;

    localparam int SETUP_CYC = 2;
    localparam int VALID_CYC = 1;
    localparam int HOLD_CYC  = 2;
    localparam int W         = Nout * Npi;
    localparam int MODV      = 1 << Npi;

    logic           clk_adc = 1'b0;
    logic           rstb    = 1'b0;
    logic           en      = 1'b0;
    logic [Npi-1:0] max_step = '0;
    logic [W-1:0]   tgt_pi   = '0;
    logic           tgt_valid = 1'b0;
    logic           tgt_ready;
    logic [W-1:0]   ctl_pi;
    logic           ctl_valid;
    logic           busy;
    logic [15:0]    n_updates;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] strobes[$];
    logic [W-1:0] exp_q[$];

    pi_ctl_sequencer #(
        .SETUP_CYC (SETUP_CYC),
        .VALID_CYC (VALID_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk_adc   (clk_adc),
        .rstb      (rstb),
        .en        (en),
        .max_step  (max_step),
        .tgt_pi    (tgt_pi),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .ctl_pi    (ctl_pi),
        .ctl_valid (ctl_valid),
        .busy      (busy),
        .n_updates (n_updates)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] pack4(input int v);
        logic [W-1:0] r;
        for (int k = 0; k < Nout; k++) r[k*Npi +: Npi] = Npi'(v);
        return r;
    endfunction

    // Reference step: shortest circular move, bounded by max(ms,1), per channel.
    function automatic logic [W-1:0] model_step(input logic [W-1:0] cur, input logic [W-1:0] tgt, input int ms);
        logic [W-1:0] r;
        int s, c, t, fwd, bwd, n;
        s = (ms == 0) ? 1 : ms;
        for (int k = 0; k < Nout; k++) begin
            c   = int'(cur[k*Npi +: Npi]);
            t   = int'(tgt[k*Npi +: Npi]);
            fwd = (t - c + MODV) % MODV;
            bwd = MODV - fwd;
            if (fwd == 0)             n = c;
            else if (fwd <= MODV / 2) n = (c + ((fwd < s) ? fwd : s)) % MODV;
            else                      n = (c - ((bwd < s) ? bwd : s) + MODV) % MODV;
            r[k*Npi +: Npi] = Npi'(n);
        end
        return r;
    endfunction

    task automatic build_exp(input logic [W-1:0] start, input logic [W-1:0] tgt, input int ms);
        logic [W-1:0] cur;
        cur = start;
        exp_q.delete();
        for (int i = 0; i < 600 && cur != tgt; i++) begin
            cur = model_step(cur, tgt, ms);
            exp_q.push_back(cur);
        end
    endtask

    // Bus monitor: captures strobed codes and checks framing stability.
    logic [W-1:0] prev_pi = '0;
    int           stable_n = 0;
    int           held_n   = 0;
    bit           prev_v   = 1'b0;
    bit           watch_hold = 1'b0;
    bit           rdy_while_busy = 1'b0;

    always @(negedge clk_adc) begin
        if (!rstb) begin
            stable_n   = 0;
            watch_hold = 1'b0;
            prev_v     = 1'b0;
            prev_pi    = ctl_pi;
        end else begin
            if (busy && tgt_ready) rdy_while_busy = 1'b1;
            if (ctl_pi != prev_pi) begin
                chk("pi_chg_during_strobe", 64'(ctl_valid), 64'd0);
                if (watch_hold) chk("hold_len_ok", 64'(held_n >= HOLD_CYC), 64'd1);
                stable_n   = 0;
                watch_hold = 1'b0;
            end else begin
                stable_n++;
                if (watch_hold) held_n++;
            end
            if (ctl_valid && !prev_v) begin
                chk("setup_len_ok", 64'(stable_n >= SETUP_CYC), 64'd1);
                strobes.push_back(ctl_pi);
            end
            if (!ctl_valid && prev_v) begin
                watch_hold = 1'b1;
                held_n     = 0;
            end
            prev_v  = ctl_valid;
            prev_pi = ctl_pi;
        end
    end

    // Offer a target, optionally keep offering a different one while busy,
    // and compare the strobed code sequence against the reference.
    task automatic run_slew(input string tag, input logic [W-1:0] tgt, input int ms, input bit junk);
        int w;
        int n0;
        build_exp(ctl_pi, tgt, ms);
        n0 = int'(n_updates);
        strobes.delete();
        tgt_pi    = tgt;
        max_step  = Npi'(ms);
        tgt_valid = 1'b1;
        w = 0;
        while (!tgt_ready && w < 20) begin
            @(negedge clk_adc);
            w++;
        end
        chk({tag, "_ready"}, 64'(tgt_ready), 64'd1);
        @(negedge clk_adc);
        if (junk) tgt_pi = ~tgt;
        else      tgt_valid = 1'b0;
        w = 0;
        while (busy && w < 4000) begin
            @(negedge clk_adc);
            w++;
        end
        tgt_valid = 1'b0;
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_nstrobe"}, 64'(strobes.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < strobes.size(); i++)
            chk($sformatf("%s_code%0d", tag, i), 64'(strobes[i]), 64'(exp_q[i]));
        chk({tag, "_final"}, 64'(ctl_pi), 64'(tgt));
        chk({tag, "_nupd"}, 64'(int'(n_updates) - n0), 64'(exp_q.size()));
    endtask

    initial begin
        int w;
        int n0;
        logic [W-1:0] t;
        logic [W-1:0] near;

        #3;
        chk("rst_ctl_pi", 64'(ctl_pi), 64'd0);
        chk("rst_ctl_valid", 64'(ctl_valid), 64'd0);
        chk("rst_tgt_ready", 64'(tgt_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_n_updates", 64'(n_updates), 64'd0);
        @(negedge clk_adc);
        #2 rstb = 1'b1;
        @(negedge clk_adc);
        en = 1'b1;
        @(negedge clk_adc);

        // Basic slew from 0 to 10 in steps of 4.
        run_slew("ten", pack4(10), 4, 1'b0);
        chk("ten_s0", 64'(strobes.size() > 0 ? strobes[0] : '0), 64'(pack4(4)));
        chk("ten_s1", 64'(strobes.size() > 1 ? strobes[1] : '0), 64'(pack4(8)));
        chk("ten_n_updates", 64'(n_updates), 64'd3);

        // Position ch0=500, ch1=5, then slew across the wrap in both directions.
        t = '0; t[0 +: Npi] = 9'd500; t[Npi +: Npi] = 9'd5;
        run_slew("pos", t, 511, 1'b0);
        t = '0; t[0 +: Npi] = 9'd5; t[Npi +: Npi] = 9'd500;
        run_slew("wrap", t, 8, 1'b0);
        if (strobes.size() == 3) begin
            chk("wrap_ch0_s0", 64'(strobes[0][0 +: Npi]), 64'd508);
            chk("wrap_ch0_s1", 64'(strobes[1][0 +: Npi]), 64'd4);
            chk("wrap_ch1_s0", 64'(strobes[0][Npi +: Npi]), 64'd509);
            chk("wrap_ch1_s1", 64'(strobes[1][Npi +: Npi]), 64'd501);
        end

        // Half-circle tie goes forward in one step; max_step 0 moves by one.
        run_slew("zero", pack4(0), 511, 1'b0);
        run_slew("tie", pack4(256), 256, 1'b0);
        chk("tie_s0", 64'(strobes.size() > 0 ? strobes[0] : '0), 64'(pack4(256)));
        run_slew("ms0", pack4(259), 0, 1'b0);
        chk("ms0_s0", 64'(strobes.size() > 0 ? strobes[0] : '0), 64'(pack4(257)));

        // A different target held on the bus while busy must be ignored.
        run_slew("junk", pack4(300), 20, 1'b1);

        // Already at target: no strobe at all.
        run_slew("same", pack4(300), 5, 1'b0);

        // Randomized targets and step sizes.
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < Nout; k++) t[k*Npi +: Npi] = Npi'($urandom_range(0, MODV - 1));
            run_slew($sformatf("rnd%0d", r), t, int'($urandom_range(32, MODV - 1)), r[0]);
        end
        for (int r = 0; r < 4; r++) begin
            near = ctl_pi;
            for (int k = 0; k < Nout; k++)
                near[k*Npi +: Npi] = Npi'((int'(ctl_pi[k*Npi +: Npi]) + int'($urandom_range(0, 8)) - 4 + MODV) % MODV);
            run_slew($sformatf("small%0d", r), near, int'($urandom_range(0, 2)), 1'b0);
        end

        // Drop en during SETUP of step 2 of 5.
        run_slew("pre_en", pack4(0), 511, 1'b0);
        strobes.delete();
        n0 = int'(n_updates);
        tgt_pi = pack4(50);
        max_step = 9'd10;
        tgt_valid = 1'b1;
        w = 0;
        while (!tgt_ready && w < 20) begin @(negedge clk_adc); w++; end
        @(negedge clk_adc);
        tgt_valid = 1'b0;
        w = 0;
        while (!(strobes.size() == 1 && ctl_pi != strobes[0]) && w < 200) begin
            @(negedge clk_adc);
            w++;
        end
        chk("en_drop_in_setup", 64'(ctl_valid), 64'd0);
        en = 1'b0;
        w = 0;
        while (busy && w < 200) begin @(negedge clk_adc); w++; end
        chk("en_drop_busy", 64'(busy), 64'd0);
        chk("en_drop_nstrobe", 64'(strobes.size()), 64'd2);
        chk("en_drop_pi", 64'(ctl_pi), 64'(pack4(20)));
        chk("en_drop_nupd", 64'(int'(n_updates) - n0), 64'd2);
        repeat (3) @(negedge clk_adc);
        chk("en_drop_pi_held", 64'(ctl_pi), 64'(pack4(20)));
        en = 1'b1;
        @(negedge clk_adc);
        chk("en_back_ready", 64'(tgt_ready), 64'd1);

        chk("ready_while_busy", 64'(rdy_while_busy), 64'd0);

        // Asynchronous reset during STROBE.
        tgt_pi = pack4(100);
        max_step = 9'd10;
        tgt_valid = 1'b1;
        @(negedge clk_adc);
        tgt_valid = 1'b0;
        w = 0;
        while (!ctl_valid && w < 50) begin @(negedge clk_adc); w++; end
        chk("rst_mid_strobe_seen", 64'(ctl_valid), 64'd1);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ctl_valid), 64'd0);
        chk("async_rst_pi", 64'(ctl_pi), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_nupd", 64'(n_updates), 64'd0);
        @(negedge clk_adc);
        #2 rstb = 1'b1;
        @(negedge clk_adc);
        chk("post_rst_ready", 64'(tgt_ready), 64'd1);
        chk("post_rst_pi", 64'(ctl_pi), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
